icache_dm_param: RTL and testbench
==================================

Name: icache_dm_param

Overview:
- Parametrised direct-mapped instruction cache between the fetch stage and the tagged system bus.
- Performs a combinational hit lookup on the fetch PC and returns one instruction.
- On a miss, refills one full line as an in-order multi-beat bus burst.
- Adds over the previous fetch cache: per-line valid bits, a configurable line/bus/set geometry, a fetch-request qualifier, and a flush (invalidate-all) command that is safe against an in-flight refill.

Parameters:
- BUS_TAG_WIDTH, 13, bus tag width
- BUS_DATA_WIDTH, 64, bus data width in bits (power of 2, ≥ INSTR_WIDTH)
- ADDR_WIDTH, 64, PC / address width
- NUM_SETS, 512, number of lines (power of 2)
- LINE_BYTES, 64, line size in bytes (power of 2, LINE_BYTES*8 ≥ BUS_DATA_WIDTH)
- INSTR_WIDTH, 32, instruction width returned to the core
- REQ_TAG, 13'h1100, tag driven on a line read: SYSBUS_READ<<8 | SYSBUS_MEMORY<<12

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low (reset==0 resets on the clk rising edge)
- fetch_req  in  1  core requests an instruction at pc
- pc  in  ADDR_WIDTH  fetch address; bits [1:0] are ignored
- flush  in  1  one-cycle pulse; invalidate all lines
- instr_reg  out  INSTR_WIDTH  instruction on hit, else 0
- data_ack  out  1  hit indication (combinational)
- refill_busy  out  1  refill FSM not in IDLE
- bus_reqcyc  out  1  request valid
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address, zero-extended
- bus_reqtag  out  BUS_TAG_WIDTH  REQ_TAG while bus_reqcyc is high, else 0
- bus_reqack  in  1  bus accepted the request
- bus_respcyc  in  1  response beat valid
- bus_respack  out  1  beat acknowledge
- bus_resp  in  BUS_DATA_WIDTH  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag; not checked

Behaviour:
- Derived quantities:
  - OFF = log2(LINE_BYTES); IDX = log2(NUM_SETS); TAGW = ADDR_WIDTH - IDX - OFF.
  - BEATS = LINE_BYTES*8 / BUS_DATA_WIDTH.
  - Address fields: index = pc[OFF+IDX-1:OFF]; tag = pc[ADDR_WIDTH-1:OFF+IDX].
- Storage: data array NUM_SETS x LINE_BYTES*8, tag array NUM_SETS x TAGW, valid array NUM_SETS x 1.
- Hit (combinational): data_ack = fetch_req & valid[index] & (tag_arr[index]==tag).
  - instr_reg = INSTR_WIDTH-bit word number pc[OFF-1:2] of the line on a hit, else 0.
  - Zero-cycle latency.
- Refill FSM, states IDLE, REQ, RESP:
  - IDLE→REQ when fetch_req & !data_ack & reset==1.
    - Latch the line address {tag,index,OFF'b0} into miss_addr.
    - Clear the beat counter.
    - Next cycle: bus_reqcyc=1, bus_req=miss_addr, bus_reqtag=REQ_TAG.
  - REQ: hold bus_reqcyc, bus_req and bus_reqtag stable until a cycle with bus_reqack=1, then →RESP. bus_reqcyc drops the cycle after.
  - RESP: bus_respack=1 for the whole state.
    - Each cycle with bus_respcyc=1 is one beat: beat k writes bus_resp into line bits [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] of set miss_addr index, then the counter increments.
    - Gaps (bus_respcyc=0) hold the counter.
  - Last beat (k = BEATS-1) completion, on the same edge:
    - write tag_arr = miss_addr tag;
    - set valid = 1 unless a flush is pending;
    - →IDLE.
  - The refilled line hits from the next cycle onward.
- valid stays 0 for the line being filled throughout the refill; partial lines never hit.
- PC changes during a refill do not redirect it; the refill completes into miss_addr.
  - A new miss is only taken in IDLE.
  - Hits to other lines are served during refill.
- Beats arriving outside RESP are ignored; bus_respack stays 0 for them.
- refill_busy = (state != IDLE), registered.
- Flush:
  - In IDLE: all valid bits clear on the next edge, and no refill starts that cycle.
  - In REQ/RESP: set flush_pending; at completion all valid bits clear, the refilled line included; flush_pending clears.
  - A flush coinciding with the last beat counts as pending.
- Reset (reset==0):
  - Clears all valid bits, flush_pending and the beat counter; state=IDLE.
  - bus_reqcyc=0, bus_respack=0, bus_req=0, refill_busy=0; bus_reqtag=0 because bus_reqcyc=0.
  - Data and tag arrays are not cleared.
  - Reset mid-refill abandons the burst; the bus is expected to be reset alongside.
- No miss request is issued while reset==0.

Test Plan:
- Defaults (BEATS=8, TAGW=49):
  - After reset, fetch_req=1, pc=0x1000 → data_ack=0; next cycle bus_reqcyc=1, bus_req=0x1000, bus_reqtag=0x1100.
- Refill with a gap:
  - reqack after 3 cycles; 8 beats 0x11..0x88 (data word i = 0x11*(i+1) replicated in both halves), one gap of bus_respcyc=0 after beat 4 → bus_respack held high in RESP.
  - Next cycle pc=0x1000 hits with instr_reg=0x00000011; pc=0x103C returns the upper half of beat 7 (0x00000088).
- Conflict:
  - pc=0x9000 (same index 64, different tag) misses and refills.
  - pc=0x1000 then misses again.
- Flush:
  - flush pulse in RESP at beat 3 → after completion pc=0x9000 misses.
  - A flush in IDLE invalidates the 0x1000 line.
- Mid-refill reset and parameter variant:
  - reset=0 at beat 5 → bus_respack=0 and refill_busy=0 next edge; the line does not hit afterwards.
  - NUM_SETS=64, LINE_BYTES=32, BUS_DATA_WIDTH=128 → BEATS=2; hit/refill repeated with the correct word selection.

Source files
------------

// File: rtl/icache_dm_param.sv
// ---------------------------------------------------------------------------
// icache_dm_param
// Direct-mapped instruction cache that sits between the fetch stage and the
// tagged system bus. The fetch PC is looked up combinationally and one
// instruction is returned in the same cycle. On a miss, the whole line is
// refilled as an in-order multi-beat burst. A flush command invalidates all
// lines. A flush that arrives during a refill is deferred until the burst
// completes, so the line being refilled is also left invalid.
//
// Ports
//   clk          clock
//   reset        synchronous reset, active-low
//   fetch_req    core requests an instruction at pc
//   pc           fetch address (bits [1:0] ignored)
//   flush        one-cycle pulse, invalidate all lines
//   instr_reg    instruction on a hit, else 0
//   data_ack     hit indication (combinational)
//   refill_busy  refill FSM not idle (registered)
//   bus_reqcyc   bus request valid
//   bus_req      line-aligned request address, zero-extended
//   bus_reqtag   REQ_TAG while bus_reqcyc is high, else 0
//   bus_reqack   bus accepted the request
//   bus_respcyc  response beat valid
//   bus_respack  beat acknowledge, high for the whole response phase
//   bus_resp     response data
//   bus_resptag  response tag (not checked)
// ---------------------------------------------------------------------------
module icache_dm_param #(
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int NUM_SETS       = 512,
  parameter int LINE_BYTES     = 64,
  parameter int INSTR_WIDTH    = 32,
  parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG = 13'h1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_req,
  input  logic [ADDR_WIDTH-1:0]     pc,
  input  logic                      flush,
  output logic [INSTR_WIDTH-1:0]    instr_reg,
  output logic                      data_ack,
  output logic                      refill_busy,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(NUM_SETS);
  localparam int TAGW   = ADDR_WIDTH - IDX - OFF;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_W / BUS_DATA_WIDTH;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  // Storage arrays (data and tag are never reset)
  logic [LINE_W-1:0]   r_data [NUM_SETS];
  logic [TAGW-1:0]     r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;

  // Refill control
  state_t              r_state;
  logic [BCW-1:0]      r_beat;
  logic                r_flush_pend;
  logic [TAGW-1:0]     r_miss_tag;
  logic [IDX-1:0]      r_miss_idx;
  logic                r_reqcyc;
  logic                r_respack;
  logic                r_busy;
  logic [BUS_DATA_WIDTH-1:0] r_req;
  logic [BUS_TAG_WIDTH-1:0]  r_reqtag;

  logic [IDX-1:0]        w_idx;
  logic [TAGW-1:0]       w_tag;
  logic [OFF-3:0]        w_word;
  logic [LINE_W-1:0]     w_line;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_miss_addr;
  logic                  w_beat_we;
  logic                  w_last;
  logic                  w_unused;

  assign w_idx       = pc[OFF+IDX-1:OFF];
  assign w_tag       = pc[ADDR_WIDTH-1:OFF+IDX];
  assign w_word      = pc[OFF-1:2];
  assign w_line      = r_data[w_idx];
  assign w_miss_addr = {w_tag, w_idx, {OFF{1'b0}}};

  // Zero-latency lookup. The valid bit is cleared for the line under refill,
  // so a partially written line can never hit.
  assign w_hit     = fetch_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign data_ack  = w_hit;
  assign instr_reg = w_hit ? w_line[w_word*INSTR_WIDTH +: INSTR_WIDTH] : '0;

  // A beat is accepted only in the response phase and never while reset is asserted.
  assign w_beat_we = reset & (r_state == S_RESP) & bus_respcyc;
  assign w_last    = w_beat_we & (r_beat == LAST_BEAT);

  assign refill_busy = r_busy;
  assign bus_reqcyc  = r_reqcyc;
  assign bus_req     = r_req;
  assign bus_reqtag  = r_reqtag;
  assign bus_respack = r_respack;

  // The response tag and the byte-offset bits of the PC carry no information here.
  assign w_unused = ^{bus_resptag, pc[1:0]};

  // Data/tag write port: one beat slice per accepted beat, tag on the last beat
  always_ff @(posedge clk) begin
    if (w_beat_we) begin
      r_data[r_miss_idx][r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
    end
    if (w_last) begin
      r_tag[r_miss_idx] <= r_miss_tag;
    end
  end

  // Refill FSM with registered bus-side outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_beat       <= '0;
      r_reqcyc     <= 1'b0;
      r_respack    <= 1'b0;
      r_busy       <= 1'b0;
      r_req        <= '0;
      r_reqtag     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            // Flush has priority: nothing is refilled in this cycle.
            r_valid <= '0;
          end else if (fetch_req && !w_hit) begin
            r_miss_tag     <= w_tag;
            r_miss_idx     <= w_idx;
            r_valid[w_idx] <= 1'b0;
            r_beat         <= '0;
            r_req          <= BUS_DATA_WIDTH'(w_miss_addr);
            r_reqtag       <= REQ_TAG;
            r_reqcyc       <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) r_flush_pend <= 1'b1;
          if (bus_reqack) begin
            r_reqcyc  <= 1'b0;
            r_reqtag  <= '0;
            r_respack <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush) r_flush_pend <= 1'b1;
          if (bus_respcyc) begin
            if (r_beat == LAST_BEAT) begin
              // A flush on the final beat counts as pending. The later
              // assignment to r_flush_pend below overrides the one above.
              if (r_flush_pend || flush) r_valid <= '0;
              else                       r_valid[r_miss_idx] <= 1'b1;
              r_flush_pend <= 1'b0;
              r_respack    <= 1'b0;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm_param.sv
// ---------------------------------------------------------------------------
// Testbench for icache_dm_param.
// Two instances are built: the default geometry (A) and a small variant (B)
// with 64 sets, 32-byte lines and a 128-bit bus. Both instances share the
// fetch/flush/reset stimulus. Bus handshakes are routed to the selected
// instance only, and its outputs are muxed onto the o_* observation signals.
// The reference model holds per-set valid/tag state and, in random mode, a
// static memory image. Expected instruction values come from the memory
// image, not from the data that was written into the cache.
// ---------------------------------------------------------------------------
module tb_icache_dm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, fetch_req, flush, bus_reqack, bus_respcyc;
  logic [63:0]  pc;
  logic [127:0] bus_resp;
  logic [12:0]  bus_resptag;
  logic         sel;

  logic [31:0] a_instr, b_instr;
  logic        a_ack, a_busy, a_reqcyc, a_respack;
  logic        b_ack, b_busy, b_reqcyc, b_respack;
  logic [63:0]  a_req;
  logic [127:0] b_req;
  logic [12:0]  a_reqtag, b_reqtag;

  icache_dm_param u_a (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .instr_reg(a_instr), .data_ack(a_ack), .refill_busy(a_busy),
    .bus_reqcyc(a_reqcyc), .bus_req(a_req), .bus_reqtag(a_reqtag),
    .bus_reqack(bus_reqack & ~sel), .bus_respcyc(bus_respcyc & ~sel),
    .bus_respack(a_respack), .bus_resp(bus_resp[63:0]), .bus_resptag(bus_resptag)
  );

  icache_dm_param #(.NUM_SETS(64), .LINE_BYTES(32), .BUS_DATA_WIDTH(128)) u_b (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .instr_reg(b_instr), .data_ack(b_ack), .refill_busy(b_busy),
    .bus_reqcyc(b_reqcyc), .bus_req(b_req), .bus_reqtag(b_reqtag),
    .bus_reqack(bus_reqack & sel), .bus_respcyc(bus_respcyc & sel),
    .bus_respack(b_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  logic [31:0]  o_instr;
  logic         o_ack, o_busy, o_reqcyc, o_respack;
  logic [127:0] o_req;
  logic [12:0]  o_reqtag;
  assign o_instr   = sel ? b_instr   : a_instr;
  assign o_ack     = sel ? b_ack     : a_ack;
  assign o_busy    = sel ? b_busy    : a_busy;
  assign o_reqcyc  = sel ? b_reqcyc  : a_reqcyc;
  assign o_respack = sel ? b_respack : a_respack;
  assign o_req     = sel ? b_req     : {64'b0, a_req};
  assign o_reqtag  = sel ? b_reqtag  : a_reqtag;

  // Geometry of the selected instance
  int g_off, g_idx, g_beats, g_bw, g_lb, g_sets;

  // Reference model
  bit          m_valid [512];
  logic [63:0] m_tag   [512];
  bit          pat_mode, side_en;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int f_set(input logic [63:0] a);
    return int'((a >> g_off) & 64'(g_sets - 1));
  endfunction

  function automatic logic [63:0] f_tag(input logic [63:0] a);
    return a >> (g_off + g_idx);
  endfunction

  function automatic bit m_hit(input logic [63:0] a);
    return m_valid[f_set(a)] && (m_tag[f_set(a)] == f_tag(a));
  endfunction

  function automatic logic [31:0] mem32(input logic [63:0] w);
    logic [31:0] x;
    x = w[31:0] * 32'h9E3779B1;
    return x ^ w[63:32] ^ 32'h5A5A0F0F;
  endfunction

  // Pattern mode (64-bit bus only): beat k carries 0x11*(k+1) in both halves.
  function automatic logic [31:0] exp_word(input logic [63:0] a);
    int off;
    off = int'(a % 64'(g_lb));
    if (pat_mode) return 32'(17 * (off / 8 + 1));
    return mem32(a >> 2);
  endfunction

  function automatic logic [127:0] beat_data(input logic [63:0] line, input int k);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < g_bw / 32; j++) begin
      if (pat_mode) r[j*32 +: 32] = 32'(17 * (k + 1));
      else          r[j*32 +: 32] = mem32((line + 64'(k * g_bw / 8)) / 4 + 64'(j));
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] t;
    t = ($urandom % 4 == 3) ? (64'hFFFF_FFFF_FFFF_FFFF >> (g_off + g_idx)) : 64'($urandom % 3);
    return (t << (g_off + g_idx)) | (64'($urandom % 3) << g_off) | 64'($urandom % g_lb);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
  endtask

  // Checks the combinational lookup for the fetch_req/pc currently driven.
  task automatic check_comb(input string tg);
    bit h;
    #1;
    h = fetch_req && m_hit(pc);
    chk({tg, "_ack"}, 128'(o_ack), 128'(h));
    chk({tg, "_instr"}, 128'(o_instr), h ? 128'(exp_word(pc)) : 128'(0));
  endtask

  task automatic side_fetch();
    fetch_req = side_en ? 1'($urandom % 2) : 1'b0;
    if (side_en) pc = rand_pc();
    check_comb("side");
  endtask

  task automatic fetch(input logic [63:0] a, input bit fl, output bit miss);
    @(negedge clk);
    fetch_req = 1'b1; pc = a; flush = fl; bus_reqack = 1'b0; bus_respcyc = 1'b0;
    miss = !m_hit(a) && !fl;
    check_comb(fl ? "flfetch" : "fetch");
    if (fl) clear_model();
    if (miss) m_valid[f_set(a)] = 1'b0;
  endtask

  task automatic idle_chk(input string tg);
    @(negedge clk);
    fetch_req = 1'b0; flush = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
    chk({tg, "_reqcyc"}, 128'(o_reqcyc), 128'(0));
    chk({tg, "_busy"}, 128'(o_busy), 128'(0));
    chk({tg, "_respack"}, 128'(o_respack), 128'(0));
  endtask

  // Serves one burst for the miss on address a that was just taken.
  task automatic refill(input logic [63:0] a, input int ack_dly, input int gap_at,
                        input int flush_at, input int rst_at, input bit rgaps);
    logic [63:0] line;
    int k;
    bit flushed, gap_done, gap;
    line = a & ~64'(g_lb - 1);
    flushed = 0; gap_done = 0;
    for (int d = 0; d <= ack_dly; d++) begin
      @(negedge clk);
      chk("req_reqcyc", 128'(o_reqcyc), 128'(1));
      chk("req_addr", o_req, 128'(line));
      chk("req_tag", 128'(o_reqtag), 128'(13'h1100));
      chk("req_busy", 128'(o_busy), 128'(1));
      chk("req_respack", 128'(o_respack), 128'(0));
      bus_reqack = (d == ack_dly); flush = 1'b0; bus_respcyc = 1'b0;
      side_fetch();
    end
    k = 0;
    while (k < g_beats) begin
      @(negedge clk);
      bus_reqack = 1'b0;
      chk("resp_respack", 128'(o_respack), 128'(1));
      chk("resp_reqcyc", 128'(o_reqcyc), 128'(0));
      chk("resp_reqtag", 128'(o_reqtag), 128'(0));
      chk("resp_busy", 128'(o_busy), 128'(1));
      if (k == rst_at) begin
        reset = 1'b0; bus_respcyc = 1'b1; bus_resp = beat_data(line, k);
        fetch_req = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("midrst_respack", 128'(o_respack), 128'(0));
        chk("midrst_busy", 128'(o_busy), 128'(0));
        chk("midrst_reqcyc", 128'(o_reqcyc), 128'(0));
        reset = 1'b1; bus_respcyc = 1'b0;
        clear_model();
        return;
      end
      gap = (k == gap_at && !gap_done) || (rgaps && ($urandom % 4 == 0));
      if (gap) begin
        if (k == gap_at) gap_done = 1;
        bus_respcyc = 1'b0; flush = 1'b0;
      end else begin
        bus_respcyc = 1'b1; bus_resp = beat_data(line, k);
        flush = (k == flush_at);
        if (k == flush_at) flushed = 1;
        k++;
      end
      side_fetch();
    end
    @(negedge clk);
    bus_respcyc = 1'b0; flush = 1'b0; fetch_req = 1'b0;
    chk("done_busy", 128'(o_busy), 128'(0));
    chk("done_respack", 128'(o_respack), 128'(0));
    if (flushed) clear_model();
    else begin
      m_valid[f_set(a)] = 1'b1;
      m_tag[f_set(a)]   = f_tag(a);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; fetch_req = 1'b1; pc = 64'h1000; flush = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0;
    @(negedge clk);
    chk("rst_reqcyc", 128'(o_reqcyc), 128'(0));
    chk("rst_respack", 128'(o_respack), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_req", o_req, 128'(0));
    chk("rst_reqtag", 128'(o_reqtag), 128'(0));
    #1 chk("rst_ack", 128'(o_ack), 128'(0));
    @(negedge clk);
    chk("rst_noreq", 128'(o_reqcyc), 128'(0));
    reset = 1'b1; fetch_req = 1'b0;
    clear_model();
  endtask

  task automatic stray_beat();
    @(negedge clk);
    fetch_req = 1'b0; flush = 1'b0; bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom, $urandom, $urandom};
    idle_chk("stray");
  endtask

  task automatic random_run(input int n);
    bit miss;
    logic [63:0] a;
    int r, fa;
    pat_mode = 0; side_en = 1;
    do_reset();
    fetch(64'h1000, 0, miss);
    if (miss) refill(64'h1000, 1, -1, -1, -1, 0);
    fetch(64'h101C, 0, miss);
    repeat (n) begin
      r = int'($urandom % 10);
      if (r < 7) begin
        a = rand_pc();
        fetch(a, 0, miss);
        fa = ($urandom % 5 == 0) ? int'($urandom % g_beats) : -1;
        if (miss) refill(a, int'($urandom % 4), -1, fa, -1, 1);
      end else if (r == 7) begin
        fetch(rand_pc(), 1, miss);
        idle_chk("flush_idle");
      end else begin
        stray_beat();
      end
    end
  endtask

  initial begin
    bit miss;
    reset = 1'b0; fetch_req = 1'b0; flush = 1'b0; pc = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    sel = 1'b0;
    g_off = 6; g_idx = 9; g_beats = 8; g_bw = 64; g_lb = 64; g_sets = 512;
    clear_model();
    pat_mode = 1; side_en = 0;

    // Directed sequence on the default geometry
    do_reset();
    fetch(64'h1000, 0, miss);
    refill(64'h1000, 3, 5, -1, -1, 0);
    fetch(64'h1000, 0, miss);
    chk("hit_1000", 128'(o_instr), 128'(32'h11));
    fetch(64'h103C, 0, miss);
    chk("hit_103C", 128'(o_instr), 128'(32'h88));
    fetch(64'h9000, 0, miss);
    refill(64'h9000, 1, -1, -1, -1, 0);
    fetch(64'h1000, 0, miss);
    refill(64'h1000, 0, -1, 3, -1, 0);
    fetch(64'h1000, 0, miss);
    refill(64'h1000, 0, -1, -1, -1, 0);
    fetch(64'h9000, 0, miss);
    refill(64'h9000, 2, -1, 7, -1, 0);
    fetch(64'h9000, 0, miss);
    refill(64'h9000, 0, -1, -1, -1, 0);
    fetch(64'h9000, 1, miss);
    idle_chk("flush_hit");
    fetch(64'h9000, 0, miss);
    refill(64'h9000, 0, -1, -1, -1, 0);
    fetch(64'h1000, 1, miss);
    idle_chk("flush_miss");
    stray_beat();
    fetch(64'h2040, 0, miss);
    refill(64'h2040, 0, -1, -1, 5, 0);
    fetch(64'h2040, 0, miss);
    refill(64'h2040, 0, -1, -1, -1, 0);
    fetch(64'h2044, 0, miss);

    random_run(150);

    // Variant geometry
    sel = 1'b1;
    g_off = 5; g_idx = 6; g_beats = 2; g_bw = 128; g_lb = 32; g_sets = 64;
    random_run(150);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
